count_ctrl: RTL and testbench

Round-robin controller that shares a single up/down counter among `NUM_REQ` requesters. Each cycle it grants at most one pending request, and applies that requester's increment or decrement to the counter. Out-of-range requests are consumed without changing the count and are reported. It sits between independent event sources and the shared event counter, replacing direct wiring of `up`/`down`.

---
 rtl/count_ctrl_pkg.sv | 14 +
 rtl/count_ctrl_rr_arbiter.sv | 50 +++++
 rtl/count_ctrl.sv | 84 ++++++++
 tb/tb_count_ctrl.sv | 150 +++++++++++++++
 4 files changed

// File: rtl/count_ctrl_pkg.sv
// Shared types and helpers for the round-robin shared-counter controller.
package count_ctrl_pkg;

   typedef enum logic {
      DIR_DOWN = 1'b0,
      DIR_UP   = 1'b1
   } dir_t;

   // Index following k in a ring of n requesters.
   function automatic int unsigned next_ptr(input int unsigned k, input int unsigned n);
      return (k + 32'd1 >= n) ? 32'd0 : k + 32'd1;
   endfunction

endpackage

// File: rtl/count_ctrl_rr_arbiter.sv
// Round-robin arbiter: one-hot combinational grant, rotating priority pointer.
module rr_arbiter
   import count_ctrl_pkg::*;
#(
   parameter int unsigned  NUM_REQ = 4,
   localparam int unsigned IDW     = $clog2(NUM_REQ)
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [NUM_REQ-1:0] req,
   input  logic               en,
   output logic [NUM_REQ-1:0] gnt,
   output logic [IDW-1:0]     gnt_id,
   output logic               gnt_valid
);

   logic [IDW-1:0] ptr_q, ptr_d;
   logic [IDW-1:0] cand;
   int unsigned    idx;
   logic           found;

   // Scan from ptr upward (mod NUM_REQ); the first pending request wins.
   always_comb begin
      gnt    = '0;
      gnt_id = '0;
      found  = 1'b0;
      idx    = 32'd0;
      cand   = '0;
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
         idx  = (32'(ptr_q) + i) % NUM_REQ;
         cand = IDW'(idx);
         if (en && !rst && !found && req[cand]) begin
            gnt[cand] = 1'b1;
            gnt_id    = cand;
            found     = 1'b1;
         end
      end
      gnt_valid = found;
      ptr_d     = found ? IDW'(next_ptr(32'(gnt_id), NUM_REQ)) : ptr_q;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         ptr_q <= '0;
      end else begin
         ptr_q <= ptr_d;
      end
   end

endmodule

// File: rtl/count_ctrl.sv
// Shares one saturating up/down counter among NUM_REQ requesters via round-robin grants.
module count_ctrl
   import count_ctrl_pkg::*;
#(
   parameter int unsigned     NUM_REQ   = 4,
   parameter int unsigned     WIDTH     = 16,
   parameter logic [WIDTH-1:0] MAX_VALUE = '1,
   parameter logic [WIDTH-1:0] MIN_VALUE = '0,
   localparam int unsigned    IDW       = $clog2(NUM_REQ)
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               clr,
   input  logic [NUM_REQ-1:0] req,
   input  logic [NUM_REQ-1:0] dir,
   output logic [NUM_REQ-1:0] gnt,
   output logic               gnt_valid,
   output logic [WIDTH-1:0]   count,
   output logic               sat,
   output logic [IDW-1:0]     sat_id
);

   logic [IDW-1:0]   gnt_id;
   logic [WIDTH-1:0] count_q, count_d;
   logic             sat_q, sat_d;
   logic [IDW-1:0]   sat_id_q, sat_id_d;
   dir_t             gnt_dir;

   rr_arbiter #(
      .NUM_REQ (NUM_REQ)
   ) u_arb (
      .clk       (clk),
      .rst       (rst),
      .req       (req),
      .en        (!clr),
      .gnt       (gnt),
      .gnt_id    (gnt_id),
      .gnt_valid (gnt_valid)
   );

   // Clear wins over any grant; a grant at a bound holds the count and flags sat.
   always_comb begin
      count_d  = count_q;
      sat_d    = 1'b0;
      sat_id_d = sat_id_q;
      gnt_dir  = dir_t'(dir[gnt_id]);
      if (clr) begin
         count_d = MIN_VALUE;
      end else if (gnt_valid) begin
         if (gnt_dir == DIR_UP) begin
            if (count_q == MAX_VALUE) begin
               sat_d    = 1'b1;
               sat_id_d = gnt_id;
            end else begin
               count_d = count_q + WIDTH'(1);
            end
         end else begin
            if (count_q == MIN_VALUE) begin
               sat_d    = 1'b1;
               sat_id_d = gnt_id;
            end else begin
               count_d = count_q - WIDTH'(1);
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         count_q  <= MIN_VALUE;
         sat_q    <= 1'b0;
         sat_id_q <= '0;
      end else begin
         count_q  <= count_d;
         sat_q    <= sat_d;
         sat_id_q <= sat_id_d;
      end
   end

   assign count  = count_q;
   assign sat    = sat_q;
   assign sat_id = sat_id_q;

endmodule

// File: tb/tb_count_ctrl.sv
// Directed-vector bench for count_ctrl: default instance plus a narrow WIDTH=4 instance.
module tb_count_ctrl;

   logic        clk = 1'b0;
   logic        rst, clr, clr_s;
   logic [3:0]  req, dir, req_s, dir_s;
   logic [3:0]  gnt, gnt_s;
   logic        gnt_valid, gnt_valid_s;
   logic [15:0] count;
   logic [3:0]  count_s;
   logic        sat, sat_s;
   logic [1:0]  sat_id, sat_id_s;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   count_ctrl #(.NUM_REQ(4), .WIDTH(16)) dut (
      .clk(clk), .rst(rst), .clr(clr), .req(req), .dir(dir),
      .gnt(gnt), .gnt_valid(gnt_valid), .count(count), .sat(sat), .sat_id(sat_id)
   );

   count_ctrl #(.NUM_REQ(4), .WIDTH(4), .MAX_VALUE(4'd10), .MIN_VALUE(4'd2)) dut_s (
      .clk(clk), .rst(rst), .clr(clr_s), .req(req_s), .dir(dir_s),
      .gnt(gnt_s), .gnt_valid(gnt_valid_s), .count(count_s), .sat(sat_s), .sat_id(sat_id_s)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Drive one cycle on the default instance: grant checked mid-cycle, registers after the edge.
   task automatic drive_cycle(input logic [3:0] r, input logic [3:0] d, input logic c,
                              input logic [3:0] exp_gnt, input logic [15:0] exp_cnt,
                              input logic exp_sat, input logic [1:0] exp_id, input string tag);
      req = r;
      dir = d;
      clr = c;
      #1;
      check({tag, "_gnt"}, 32'(gnt), 32'(exp_gnt));
      check({tag, "_gvld"}, 32'(gnt_valid), 32'(exp_gnt != 4'd0));
      tick();
      check({tag, "_cnt"}, 32'(count), 32'(exp_cnt));
      check({tag, "_sat"}, 32'(sat), 32'(exp_sat));
      if (exp_sat) check({tag, "_satid"}, 32'(sat_id), 32'(exp_id));
   endtask

   task automatic drive_small(input logic [3:0] r, input logic [3:0] d, input logic c,
                              input logic [3:0] exp_gnt, input logic [3:0] exp_cnt,
                              input logic exp_sat, input logic [1:0] exp_id, input string tag);
      req_s = r;
      dir_s = d;
      clr_s = c;
      #1;
      check({tag, "_gnt"}, 32'(gnt_s), 32'(exp_gnt));
      tick();
      check({tag, "_cnt"}, 32'(count_s), 32'(exp_cnt));
      check({tag, "_sat"}, 32'(sat_s), 32'(exp_sat));
      if (exp_sat) check({tag, "_satid"}, 32'(sat_id_s), 32'(exp_id));
   endtask

   initial begin
      logic [15:0] alt_cnt [4];
      logic        alt_sat [4];
      alt_cnt = '{16'd0, 16'd1, 16'd0, 16'd1};
      alt_sat = '{1'b1, 1'b0, 1'b0, 1'b0};

      rst = 1'b1; clr = 1'b0; req = 4'b0001; dir = 4'b0001;
      clr_s = 1'b0; req_s = 4'b0000; dir_s = 4'b0000;
      tick();
      tick();
      #1;
      check("rst_gnt", 32'(gnt), 32'd0);
      check("rst_gvld", 32'(gnt_valid), 32'd0);
      check("rst_cnt", 32'(count), 32'd0);
      check("rst_sat", 32'(sat), 32'd0);
      check("rst_satid", 32'(sat_id), 32'd0);
      check("rst_cnt_s", 32'(count_s), 32'd2);
      tick();
      rst = 1'b0;

      // Single requester counting up
      for (int i = 1; i <= 5; i++)
         drive_cycle(4'b0001, 4'b0001, 1'b0, 4'b0001, 16'(i), 1'b0, 2'd0, "single");

      // Reset with a request pending: no grant, state back to reset values
      rst = 1'b1;
      #1;
      check("rst2_gnt", 32'(gnt), 32'd0);
      tick();
      check("rst2_cnt", 32'(count), 32'd0);
      rst = 1'b0;

      // All four requesting, alternating up/down starting at ptr 0
      for (int i = 0; i < 8; i++)
         drive_cycle(4'b1111, 4'b0101, 1'b0, 4'(1 << (i % 4)), (i % 2 == 0) ? 16'd1 : 16'd0,
                     1'b0, 2'd0, "rr0101");

      // Down-first pattern: requester 0 decrements at 0 and saturates
      for (int i = 0; i < 4; i++)
         drive_cycle(4'b1111, 4'b1010, 1'b0, 4'(1 << i), alt_cnt[i], alt_sat[i], 2'd0, "rr1010");

      // Build count to 3, then clear with requesters 1 and 3 pending
      drive_cycle(4'b0001, 4'b0001, 1'b0, 4'b0001, 16'd2, 1'b0, 2'd0, "pre_clr_a");
      drive_cycle(4'b0001, 4'b0001, 1'b0, 4'b0001, 16'd3, 1'b0, 2'd0, "pre_clr_b");
      drive_cycle(4'b1010, 4'b1010, 1'b1, 4'b0000, 16'd0, 1'b0, 2'd0, "clr");
      drive_cycle(4'b1010, 4'b1010, 1'b0, 4'b0010, 16'd1, 1'b0, 2'd0, "post_clr_a");
      drive_cycle(4'b1000, 4'b1010, 1'b0, 4'b1000, 16'd2, 1'b0, 2'd0, "post_clr_b");

      // Grant to 2, then reset mid-operation; pointer must return to 0
      drive_cycle(4'b0100, 4'b0100, 1'b0, 4'b0100, 16'd3, 1'b0, 2'd0, "pre_rst");
      req = 4'b1101; dir = 4'b0100; rst = 1'b1;
      #1;
      check("rst3_gnt", 32'(gnt), 32'd0);
      check("rst3_gvld", 32'(gnt_valid), 32'd0);
      tick();
      check("rst3_cnt", 32'(count), 32'd0);
      check("rst3_sat", 32'(sat), 32'd0);
      rst = 1'b0;
      drive_cycle(4'b1101, 4'b0001, 1'b0, 4'b0001, 16'd1, 1'b0, 2'd0, "post_rst_a");
      drive_cycle(4'b1100, 4'b0000, 1'b0, 4'b0100, 16'd0, 1'b0, 2'd0, "post_rst_b");
      drive_cycle(4'b1000, 4'b0000, 1'b0, 4'b1000, 16'd0, 1'b1, 2'd3, "min_sat3");
      drive_cycle(4'b0000, 4'b0000, 1'b0, 4'b0000, 16'd0, 1'b0, 2'd0, "sat_pulse");

      // Narrow instance: saturate at MAX_VALUE=10 then at MIN_VALUE=2 from requester 2
      for (int i = 1; i <= 12; i++)
         drive_small(4'b0100, 4'b0100, 1'b0, 4'b0100, (i >= 8) ? 4'd10 : 4'(2 + i),
                     i >= 9, 2'd2, "s_up");
      for (int i = 1; i <= 9; i++)
         drive_small(4'b0100, 4'b0000, 1'b0, 4'b0100, (i >= 8) ? 4'd2 : 4'(10 - i),
                     i == 9, 2'd2, "s_down");
      drive_small(4'b0100, 4'b0100, 1'b0, 4'b0100, 4'd3, 1'b0, 2'd0, "s_up1");
      drive_small(4'b0100, 4'b0100, 1'b1, 4'b0000, 4'd2, 1'b0, 2'd0, "s_clr");
      drive_small(4'b0000, 4'b0000, 1'b0, 4'b0000, 4'd2, 1'b0, 2'd0, "s_idle");

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
